// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field-level MIPS instruction descriptors and writes them
// to consecutive imem words from 0, holding the core in reset until loading finishes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_LOAD  | waiting for a descriptor (in_ready_o=1)
// S_WRITE | one-cycle imem write of the registered word
// S_DONE  | program loaded, core released from reset
// S_ERROR | load aborted (bad kind or imem overflow), core held in reset
module instr_encoder_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        in_kind_i,
   input  logic [4:0]        in_rs_i,
   input  logic [4:0]        in_rt_i,
   input  logic [4:0]        in_rd_i,
   input  logic [15:0]       in_imm_i,
   input  logic [25:0]       in_target_i,
   input  logic              in_last_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_reset_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [1:0] S_LOAD  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_ERROR = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic              last_q, last_d;

   logic [31:0]       enc_word;
   logic              enc_ok;

   // Opcode/funct map shared with the core's decoder; unused fields are forced to zero.
   always_comb begin
      enc_word = 32'd0;
      enc_ok   = 1'b1;
      case (in_kind_i)
         4'd0:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100000};
         4'd1:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100010};
         4'd2:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100100};
         4'd3:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b100101};
         4'd4:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'd0, 6'b101010};
         4'd5:    enc_word = {6'b100011, in_rs_i, in_rt_i, in_imm_i};
         4'd6:    enc_word = {6'b101011, in_rs_i, in_rt_i, in_imm_i};
         4'd7:    enc_word = {6'b000100, in_rs_i, in_rt_i, in_imm_i};
         4'd8:    enc_word = {6'b001000, in_rs_i, in_rt_i, in_imm_i};
         4'd9:    enc_word = {6'b000010, in_target_i};
         4'd10:   enc_word = {6'b000000, in_rs_i, 15'd0, 6'b001000};
         4'd11:   enc_word = {6'b100000, in_rs_i, in_rt_i, in_imm_i};
         default: enc_ok   = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      last_d  = last_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid_i) begin
               if (enc_ok) begin
                  word_d  = enc_word;
                  last_d  = in_last_i;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         S_WRITE: begin
            // The final-address word is always written; overflow only matters if more follow.
            if (last_q) begin
               state_d = S_DONE;
            end else if (addr_q == {ADDR_W{1'b1}}) begin
               state_d = S_ERROR;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = S_LOAD;
            end
         end
         default: begin
            if (start_i) begin
               state_d = S_LOAD;
               addr_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_LOAD;
         addr_q  <= '0;
         word_q  <= 32'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         last_q  <= last_d;
      end
   end

   // Outputs decode straight from state so an async reset kills imem_we_o at once.
   assign in_ready_o   = (state_q == S_LOAD);
   assign imem_we_o    = (state_q == S_WRITE);
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = word_q;
   assign cpu_reset_o  = (state_q != S_DONE);
   assign done_o       = (state_q == S_DONE);
   assign err_o        = (state_q == S_ERROR);

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Fills instruction memory before the MIPS core runs. It accepts field-level instruction descriptors over a valid/ready handshake and encodes each into a 32-bit MIPS word, using the same opcode/funct map the core's decoder consumes. Encoded words are written to consecutive imem addresses from 0. The core is held in reset until the program is fully loaded.

Parameters:
ADDR_W, 6, imem word-address width; capacity 2^ADDR_W words

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; restarts loading from DONE/ERROR
in_valid  in  1  descriptor valid
in_ready  out  1  loader can accept a descriptor
in_kind  in  4  instruction kind (encoding below)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_imm  in  16  immediate / branch offset
in_target  in  26  jump target (j only)
in_last  in  1  descriptor is final instruction of program
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  32  encoded instruction
cpu_reset  out  1  holds core in reset while high
done  out  1  program loaded
err  out  1  load aborted (bad kind or overflow)

Behaviour:
- Reset (async): state=LOAD; addr=0; in_ready=1; imem_we=0; imem_wdata=0; cpu_reset=1; done=0; err=0.
- States:
  - LOAD: in_ready=1. On in_valid&in_ready, register the encoded word, last flag and kind-valid flag, then go to WRITE.
  - WRITE: in_ready=0, imem_we=1, imem_addr=addr, imem_wdata=registered word, all for exactly one cycle.
  - DONE: done=1, cpu_reset=0, in_ready=0.
  - ERROR: err=1, cpu_reset=1, in_ready=0.
- WRITE exit:
  - last=1 -> DONE.
  - else addr==2^ADDR_W-1 -> ERROR (overflow; the word is still written).
  - else addr+1 and return to LOAD.
- Throughput: one descriptor per 2 cycles. Write lands the cycle after acceptance.
- Invalid kind (12-15): handshake completes, no write (imem_we stays 0), next state ERROR. in_last is ignored.
- start: honoured only in DONE/ERROR. Next cycle: LOAD, addr=0, cpu_reset=1, done=0, err=0. Ignored in LOAD/WRITE.
- Reset mid-WRITE: imem_we drops immediately (async); partial load is discarded.
- Encoding (in_kind -> word):
  - 0 add: {000000,rs,rt,rd,00000,100000}
  - 1 sub: funct 100010
  - 2 and: funct 100100
  - 3 or: funct 100101
  - 4 slt: funct 101010
  - 5 lw: {100011,rs,rt,imm}
  - 6 sw: {101011,rs,rt,imm}
  - 7 beq: {000100,rs,rt,imm}
  - 8 addi: {001000,rs,rt,imm}
  - 9 j: {000010,target}
  - 10 jr: {000000,rs,15'b0,001000}
  - 11 lb: {100000,rs,rt,imm}
- Unused fields are forced to zero regardless of input (e.g. rd for I-type; shamt always 0).

Test Plan:
1. Basic encode and load. Reset, then send add rs=1 rt=2 rd=3, lw rs=1 rt=2 imm=4, and j target=0x10 with last=1 -> imem writes 0x00221820@0, 0x8C220004@1, 0x08000010@2. Then done=1, cpu_reset=0, in_ready=0.
2. Remaining kinds. Send jr rs=31 (rd=7 garbage), beq 1,2,imm=0xFFFF, sw rs=0 rt=2 imm=8, and lb rs=5 rt=4 imm=0 (last) -> 0x03E00008, 0x1022FFFF, 0xAC020008, 0x80A40000.
3. Invalid kind. Send kind=13 as the second descriptor -> no write for it, err=1 the next cycle, cpu_reset stays 1. Then pulse start -> addr restarts at 0, err=0.
4. Overflow. With ADDR_W=2, send 4 non-last descriptors -> the 4th is written at addr 3, then err=1, done=0.
5. Handshake timing. Hold in_valid high continuously -> in_ready toggles 1,0,1,0. Exactly one imem_we pulse per accepted descriptor, one cycle after acceptance.
6. Async reset mid-WRITE. Assert reset during the imem_we cycle -> imem_we=0 immediately, addr=0, cpu_reset=1. start pulses in LOAD are ignored.
